// File: rtl/staggered_add_pipe.sv
// Staggered carry-chain adder/subtractor: one CHUNK-bit add per pipeline stage,
// LSB chunk first, with the ripple carry registered between stages.

module staggered_add_chunk #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             v_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic             v_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             c_o,
  output logic             cm_o
);
  localparam int LO = IDX * CHUNK;

  logic [CHUNK:0]   t;
  logic [WIDTH-1:0] a_n;
  logic             cm_n;

  // Completed sum chunks overwrite the operand-A bits they consumed.
  always_comb begin
    t    = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, c_i};
    a_n  = a_i;
    a_n[LO +: CHUNK] = t[CHUNK-1:0];
    // sum bit = a ^ b ^ carry-in, so the carry into the chunk MSB falls out directly
    cm_n = t[CHUNK-1] ^ a_i[LO+CHUNK-1] ^ b_i[LO+CHUNK-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_o  <= 1'b0;
      a_o  <= '0;
      b_o  <= '0;
      c_o  <= 1'b0;
      cm_o <= 1'b0;
    end else if (en) begin
      v_o  <= v_i;
      a_o  <= a_n;
      b_o  <= b_i;
      c_o  <= t[CHUNK];
      cm_o <= cm_n;
    end
  end
endmodule

module staggered_add_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("staggered_add_pipe: WIDTH must be a positive multiple of CHUNK");
  end

  logic stall, en;
  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = !stall;

  // Input register stage
  logic             v_q, c_q;
  logic [WIDTH-1:0] a_q, b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
    end else if (en) begin
      v_q <= in_valid;
      a_q <= a;
      b_q <= sub ? ~b : b;
      c_q <= sub | cin;
    end
  end

  // Index 0 is the input register; index k+1 is the output of chunk stage k.
  logic [NUM_CHUNKS:0][WIDTH-1:0] a_s, b_s;
  logic [NUM_CHUNKS:0]            c_s, vld_pipe;
  logic [NUM_CHUNKS:1]            cm_s;

  assign a_s[0]      = a_q;
  assign b_s[0]      = b_q;
  assign c_s[0]      = c_q;
  assign vld_pipe[0] = v_q;

  for (genvar k = 0; k < NUM_CHUNKS; k++) begin : g_chunk
    staggered_add_chunk #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_chunk (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .v_i  (vld_pipe[k]),
      .a_i  (a_s[k]),
      .b_i  (b_s[k]),
      .c_i  (c_s[k]),
      .v_o  (vld_pipe[k+1]),
      .a_o  (a_s[k+1]),
      .b_o  (b_s[k+1]),
      .c_o  (c_s[k+1]),
      .cm_o (cm_s[k+1])
    );
  end

  // Only the top chunk's MSB carry and nothing of the spent B' operand is needed past the chain.
  logic unused_tail;
  assign unused_tail = ^{b_s[NUM_CHUNKS], cm_s};

  // Retire stage resolves the flags so the output flops see no carry logic.
  logic             r_v, r_cout, r_ovf;
  logic [WIDTH-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (en) begin
      r_v    <= vld_pipe[NUM_CHUNKS];
      r_sum  <= a_s[NUM_CHUNKS];
      r_cout <= c_s[NUM_CHUNKS];
      r_ovf  <= c_s[NUM_CHUNKS] ^ cm_s[NUM_CHUNKS];
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= r_v;
      sum       <= r_sum;
      cout      <= r_cout;
      ovf       <= r_ovf;
    end
  end
endmodule

// File: tb/tb_staggered_add_pipe.sv
// Bench for staggered_add_pipe: directed vectors with literal expectations plus
// an arithmetic scoreboard checked on every consumed result.

module tb_staggered_add_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  logic        v16, r16, cin16, sub16, ov16, or16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  staggered_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  staggered_add_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res_t;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb);
    res_t        r;
    logic [31:0] bb;
    logic [32:0] full;
    bb   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, bb} + 33'(sb ? 1'b1 : ci);
    r.s  = full[31:0];
    r.co = full[32];
    r.ov = (x[31] == bb[31]) && (full[31] != x[31]);
    return r;
  endfunction

  res_t        expq[$];
  logic [31:0] got[$];
  res_t        e;
  bit          stream_phase = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_sum;
  logic        prev_co, prev_ov;

  // Scoreboard: what is presented at a negedge is what the next rising edge samples.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_stall = 0;
    end else begin
      chk("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("hold_sum", sum, prev_sum);
        chk("hold_flags", {cout, ovf}, {prev_co, prev_ov});
      end
      if (stream_phase && !in_ready) stall_cnt++;
      if (in_valid && in_ready) expq.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = expq.pop_front();
          chk("sb_sum", sum, e.s);
          chk("sb_cout", cout, e.co);
          chk("sb_ovf", ovf, e.ov);
          got.push_back(sum);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_co    = cout;
      prev_ov    = ovf;
    end
  end

  // Called #1 after a rising edge with the pipe idle.
  task automatic send1(input logic [31:0] x, input logic [31:0] y, input logic ci,
                       input logic sb, input logic [31:0] es, input logic eco,
                       input logic eov, input string nm);
    int n;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 20);
    chk({nm, "_latency"}, n, 6);
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, cout, eco);
    chk({nm, "_ovf"}, ovf, eov);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, v;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst16_out", {ov16, sum16, cout16, ovf16, r16}, 19'h1);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send1(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "ripple");
    send1(32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_borrow");
    send1(32'h7, 32'h5, 1'b0, 1'b1, 32'h2, 1'b1, 1'b0, "sub_noborrow");
    send1(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    send1(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");

    // Streaming with a 3-cycle backpressure window once results start.
    got.delete();
    stall_cnt    = 0;
    stream_phase = 1;
    fork
      begin
        int  k;
        bit  ok;
        for (int i = 1; i <= 10; i++) begin
          in_valid = 1'b1; a = i; b = 32'h100 * i; cin = 1'b0; sub = 1'b0;
          k = 0;
          do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            k++;
          end while (!ok && k < 50);
          if (!ok) chk("stream_accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
      end
      begin
        int m;
        m = 0;
        do begin
          @(posedge clk); #1;
          m++;
        end while (!out_valid && m < 50);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    stream_phase = 0;
    chk("stream_drained", expq.size(), 0);
    chk("stream_count", got.size(), 10);
    for (int i = 0; i < got.size() && i < 10; i++) chk("stream_value", got[i], 32'h101 * (i + 1));
    chk("stall_cycles", stall_cnt, 3);

    // Reset with four beats in flight.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; a = 32'd20 + i; b = i; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    v = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) v++;
    end
    chk("no_stale_beat", v, 0);
    send1(32'h3, 32'h4, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, "post_rst");

    // 16-bit / 4-bit chunk instance: carry crosses three chunk boundaries.
    v16 = 1'b1; a16 = 16'h0FFF; b16 = 16'h0001;
    @(posedge clk); #1;
    v16 = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov16 && n < 20);
    chk("w16_latency", n, 6);
    chk("w16_sum", sum16, 16'h1000);
    chk("w16_cout", cout16, 0);
    chk("w16_ovf", ovf16, 0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
